// File: rtl/trace_buffer.sv
// Instruction-trace capture: snoops fetches into a circular RAM around a trigger
// (pre/post window), then drains oldest-first through a registered pop port.
module trace_buffer #(
    parameter int ADDR_W     = 16,
    parameter int INSTR_W    = 24,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_clk_en,
    input  logic                      i_valid,
    input  logic [ADDR_W-1:0]         i_iaddr,
    input  logic [INSTR_W-1:0]        i_instr,
    input  logic                      i_arm,
    input  logic                      i_trig,
    input  logic [DEPTH_LOG2-1:0]     i_post_count,
    input  logic                      i_rd_en,
    output logic [ADDR_W+INSTR_W-1:0] o_rd_data,
    output logic                      o_rd_valid,
    output logic [1:0]                o_state,
    output logic [DEPTH_LOG2:0]       o_count,
    output logic                      o_wrapped
);
    localparam int DW = ADDR_W + INSTR_W;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3} state_t;

    state_t                state, state_n;
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, post_cnt;
    logic                  cap, rd_go;
    logic [DW-1:0]         mem [DEPTH];

    always_comb begin
        state_n = state;
        cap     = 1'b0;
        rd_go   = 1'b0;
        if (i_arm) begin
            state_n = ARMED;
        end else begin
            case (state)
                ARMED: begin
                    cap = i_valid;
                    if (i_trig) state_n = (i_post_count == '0) ? DONE : POST;
                end
                POST: begin
                    cap = i_valid;
                    // post_cnt is never 0 while in POST; the last post capture ends it
                    if (i_valid && post_cnt == DEPTH_LOG2'(1)) state_n = DONE;
                end
                DONE:    rd_go = i_rd_en && (o_count != '0);
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            post_cnt   <= '0;
            o_count    <= '0;
            o_wrapped  <= 1'b0;
            o_rd_valid <= 1'b0;
            o_rd_data  <= '0;
        end else if (i_clk_en) begin
            state      <= state_n;
            o_rd_valid <= rd_go;
            if (rd_go) o_rd_data <= mem[rd_ptr];
            if (i_arm) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                post_cnt  <= '0;
                o_count   <= '0;
                o_wrapped <= 1'b0;
            end else begin
                if (cap) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    // full buffer: drop the oldest entry to keep the newest history
                    if (o_count == FULL) begin
                        rd_ptr    <= rd_ptr + 1'b1;
                        o_wrapped <= 1'b1;
                    end else begin
                        o_count <= o_count + 1'b1;
                    end
                end
                if (state == ARMED && i_trig) post_cnt <= i_post_count;
                else if (state == POST && cap) post_cnt <= post_cnt - 1'b1;
                if (rd_go) begin
                    rd_ptr  <= rd_ptr + 1'b1;
                    o_count <= o_count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_clk_en && cap) mem[wr_ptr] <= {i_iaddr, i_instr};
    end

    assign o_state = state;

endmodule

// File: tb/tb_trace_buffer.sv
// Directed bench for trace_buffer at DEPTH=16: windowing, wrap, edge cases,
// clock enable, re-arm and asynchronous reset.
module tb_trace_buffer;
    localparam int AW = 16;
    localparam int IW = 24;
    localparam int DL = 4;

    logic          i_clk = 1'b0;
    logic          i_rst, i_clk_en, i_valid, i_arm, i_trig, i_rd_en;
    logic [AW-1:0] i_iaddr;
    logic [IW-1:0] i_instr;
    logic [DL-1:0] i_post_count;
    logic [AW+IW-1:0] o_rd_data;
    logic          o_rd_valid, o_wrapped;
    logic [1:0]    o_state;
    logic [DL:0]   o_count;

    int checks = 0;
    int errors = 0;

    trace_buffer #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH_LOG2(DL)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_clk_en(i_clk_en), .i_valid(i_valid),
        .i_iaddr(i_iaddr), .i_instr(i_instr), .i_arm(i_arm), .i_trig(i_trig),
        .i_post_count(i_post_count), .i_rd_en(i_rd_en), .o_rd_data(o_rd_data),
        .o_rd_valid(o_rd_valid), .o_state(o_state), .o_count(o_count),
        .o_wrapped(o_wrapped)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [IW-1:0] mk_instr(input logic [AW-1:0] a);
        return {8'hC3, a ^ 16'h5A5A};
    endfunction

    function automatic logic [AW+IW-1:0] entry(input logic [AW-1:0] a);
        return {a, mk_instr(a)};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic arm();
        i_arm = 1'b1;
        tick();
        i_arm = 1'b0;
    endtask

    task automatic fetch(input logic [AW-1:0] a, input logic trig);
        i_valid = 1'b1;
        i_iaddr = a;
        i_instr = mk_instr(a);
        i_trig  = trig;
        tick();
        i_valid = 1'b0;
        i_trig  = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_clk_en = 1'b1; i_valid = 1'b0; i_arm = 1'b0; i_trig = 1'b0;
        i_rd_en = 1'b0; i_iaddr = '0; i_instr = '0; i_post_count = '0;
        tick(); tick();
        i_rst = 1'b0;
        tick();
        checks++;
        if (o_state !== 2'd0 || o_count !== 5'd0 || o_rd_valid !== 1'b0 ||
            o_wrapped !== 1'b0 || o_rd_data !== '0) begin
            errors++;
            $display("FAIL reset: state=%0d count=%0d rv=%b wr=%b data=%h, want 0", o_state,
                     o_count, o_rd_valid, o_wrapped, o_rd_data);
        end
    endtask

    task automatic test_idle_trig();
        i_trig = 1'b1; i_valid = 1'b1; i_rd_en = 1'b1;
        tick();
        i_trig = 1'b0; i_valid = 1'b0; i_rd_en = 1'b0;
        tick();
        checks++;
        if (o_state !== 2'd0 || o_count !== 5'd0 || o_rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_trig: state=%0d count=%0d rv=%b, want 0/0/0", o_state, o_count,
                     o_rd_valid);
        end
    endtask

    task automatic test_no_wrap();
        arm();
        checks++;
        if (o_state !== 2'd1 || o_count !== 5'd0) begin
            errors++;
            $display("FAIL arm: state=%0d count=%0d, want 1/0", o_state, o_count);
        end
        i_post_count = 4'd3;
        for (int a = 0; a < 5; a++) fetch(16'(a), a == 4);
        checks++;
        if (o_state !== 2'd2 || o_count !== 5'd5) begin
            errors++;
            $display("FAIL post_enter: state=%0d count=%0d, want 2/5", o_state, o_count);
        end
        for (int a = 5; a < 8; a++) fetch(16'(a), 1'b0);
        checks++;
        if (o_state !== 2'd3 || o_count !== 5'd8 || o_wrapped !== 1'b0) begin
            errors++;
            $display("FAIL nowrap_done: state=%0d count=%0d wr=%b, want 3/8/0", o_state,
                     o_count, o_wrapped);
        end
        i_rd_en = 1'b1;
        checks++;
        if (o_rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_latency: rv=%b before edge, want 0", o_rd_valid);
        end
        for (int a = 0; a < 8; a++) begin
            tick();
            checks++;
            if (o_rd_valid !== 1'b1 || o_rd_data !== entry(16'(a))) begin
                errors++;
                $display("FAIL nowrap_drain[%0d]: rv=%b data=%h, want 1/%h", a, o_rd_valid,
                         o_rd_data, entry(16'(a)));
            end
        end
        i_rd_en = 1'b0;
        tick();
        checks++;
        if (o_rd_valid !== 1'b0 || o_count !== 5'd0) begin
            errors++;
            $display("FAIL drain_end: rv=%b count=%0d, want 0/0", o_rd_valid, o_count);
        end
    endtask

    task automatic test_over_read();
        i_rd_en = 1'b1;
        tick(); tick();
        i_rd_en = 1'b0;
        checks++;
        if (o_rd_valid !== 1'b0 || o_rd_data !== entry(16'd7) || o_count !== 5'd0) begin
            errors++;
            $display("FAIL over_read: rv=%b data=%h count=%0d, want 0/%h/0", o_rd_valid,
                     o_rd_data, o_count, entry(16'd7));
        end
    endtask

    task automatic test_wrap();
        arm();
        i_post_count = 4'd4;
        for (int a = 0; a < 40; a++) fetch(16'(a), a == 35);
        checks++;
        if (o_state !== 2'd3 || o_count !== 5'd16 || o_wrapped !== 1'b1) begin
            errors++;
            $display("FAIL wrap_done: state=%0d count=%0d wr=%b, want 3/16/1", o_state,
                     o_count, o_wrapped);
        end
        i_rd_en = 1'b1;
        for (int a = 24; a < 40; a++) begin
            tick();
            checks++;
            if (o_rd_valid !== 1'b1 || o_rd_data !== entry(16'(a))) begin
                errors++;
                $display("FAIL wrap_drain[%0d]: rv=%b data=%h, want 1/%h", a, o_rd_valid,
                         o_rd_data, entry(16'(a)));
            end
        end
        i_rd_en = 1'b0;
        tick();
    endtask

    task automatic test_post_zero();
        logic [AW+IW-1:0] last;
        arm();
        i_post_count = 4'd0;
        fetch(16'h0001, 1'b0);
        fetch(16'h0002, 1'b0);
        fetch(16'h0010, 1'b1);
        fetch(16'h0011, 1'b0);
        checks++;
        if (o_state !== 2'd3 || o_count !== 5'd3) begin
            errors++;
            $display("FAIL post0_done: state=%0d count=%0d, want 3/3", o_state, o_count);
        end
        last = '0;
        i_rd_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            last = o_rd_data;
        end
        i_rd_en = 1'b0;
        checks++;
        if (last !== entry(16'h0010)) begin
            errors++;
            $display("FAIL post0_last: data=%h, want %h", last, entry(16'h0010));
        end
        tick();
    endtask

    task automatic test_clk_en();
        arm();
        fetch(16'h0100, 1'b0);
        fetch(16'h0101, 1'b0);
        i_clk_en = 1'b0;
        i_valid = 1'b1; i_iaddr = 16'h0200; i_instr = mk_instr(16'h0200);
        repeat (3) tick();
        i_valid = 1'b0;
        checks++;
        if (o_count !== 5'd2 || o_state !== 2'd1) begin
            errors++;
            $display("FAIL clk_en_capture: count=%0d state=%0d, want 2/1", o_count, o_state);
        end
        i_clk_en = 1'b1;
        i_post_count = 4'd0;
        fetch(16'h0102, 1'b1);
        i_rd_en = 1'b1;
        tick();
        i_rd_en = 1'b0;
        i_clk_en = 1'b0;
        tick(); tick();
        checks++;
        if (o_rd_valid !== 1'b1 || o_rd_data !== entry(16'h0100) || o_count !== 5'd2) begin
            errors++;
            $display("FAIL clk_en_hold: rv=%b data=%h count=%0d, want 1/%h/2", o_rd_valid,
                     o_rd_data, o_count, entry(16'h0100));
        end
        i_clk_en = 1'b1;
        tick();
    endtask

    task automatic test_rearm();
        arm();
        i_post_count = 4'd0;
        for (int a = 0; a < 5; a++) fetch(16'(16'h0300 + a), a == 4);
        checks++;
        if (o_state !== 2'd3 || o_count !== 5'd5) begin
            errors++;
            $display("FAIL rearm_pre: state=%0d count=%0d, want 3/5", o_state, o_count);
        end
        i_rd_en = 1'b1;
        arm();
        i_rd_en = 1'b0;
        checks++;
        if (o_state !== 2'd1 || o_count !== 5'd0 || o_rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rearm: state=%0d count=%0d rv=%b, want 1/0/0", o_state, o_count,
                     o_rd_valid);
        end
    endtask

    task automatic test_async_reset();
        arm();
        i_post_count = 4'd5;
        fetch(16'h0400, 1'b1);
        fetch(16'h0401, 1'b0);
        checks++;
        if (o_state !== 2'd2) begin
            errors++;
            $display("FAIL async_pre: state=%0d, want 2", o_state);
        end
        #2;
        i_rst = 1'b1;
        #1;
        checks++;
        if (o_state !== 2'd0 || o_count !== 5'd0 || o_rd_valid !== 1'b0 || o_wrapped !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: state=%0d count=%0d rv=%b wr=%b, want 0", o_state,
                     o_count, o_rd_valid, o_wrapped);
        end
        tick();
        i_rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_idle_trig();
        test_no_wrap();
        test_over_read();
        test_wrap();
        test_post_zero();
        test_clk_en();
        test_rearm();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trace_buffer.md
Name: trace_buffer

Overview:
- Synthesizable instruction-trace capture unit; replaces simulation-only fetch printing with on-chip capture.
- Sits beside the CPU and snoops each fetch (instruction address plus instruction word) into a parametrised circular RAM.
- Capture uses a pre/post-trigger window. Software or a debug port drains the buffer oldest-first through a pop interface.

Parameters:
ADDR_W, 16, instruction address width
INSTR_W, 24, instruction word width
DEPTH_LOG2, 6, log2 of buffer depth (DEPTH = 2**DEPTH_LOG2 entries)

Ports:
i_clk  input  1  system clock
i_rst  input  1  asynchronous reset, active-high
i_clk_en  input  1  global clock enable; all state holds when low
i_valid  input  1  fetch valid this cycle
i_iaddr  input  ADDR_W  fetch address
i_instr  input  INSTR_W  fetched instruction
i_arm  input  1  clear buffer and start capture
i_trig  input  1  trigger event
i_post_count  input  DEPTH_LOG2  entries to capture after trigger entry
i_rd_en  input  1  pop oldest entry
o_rd_data  output  ADDR_W+INSTR_W  {iaddr, instr} of popped entry
o_rd_valid  output  1  o_rd_data valid (one-cycle pulse)
o_state  output  2  0=IDLE 1=ARMED 2=POST 3=DONE
o_count  output  DEPTH_LOG2+1  entries held, 0..DEPTH
o_wrapped  output  1  pre-trigger history overwritten at least once

Behaviour:
- Reset (async, i_rst=1): state IDLE; wr_ptr, rd_ptr, o_count, post counter = 0; o_rd_valid=0; o_rd_data=0; o_wrapped=0. Buffer RAM contents undefined.
- Every sequential update is qualified by i_clk_en. When i_clk_en is low, all outputs hold, including o_rd_valid.
- IDLE:
  - i_arm -> ARMED, with pointers, count and o_wrapped cleared.
  - i_trig, i_valid and i_rd_en are ignored.
- ARMED:
  - Each i_valid writes {i_iaddr,i_instr} at wr_ptr, and wr_ptr increments mod DEPTH.
  - o_count increments and saturates at DEPTH.
  - A write with count already DEPTH advances rd_ptr with wr_ptr and sets o_wrapped.
  - i_trig -> POST, with post counter loaded from i_post_count.
  - If i_valid and i_trig are both high in the same cycle, the fetch is captured and is the trigger entry.
- POST:
  - Each i_valid captures as in ARMED and decrements the post counter.
  - When the post counter is 0 at the trigger cycle, or reaches 0 on a capture, the next state is DONE.
  - i_post_count=0 therefore ends capture on the trigger entry itself.
  - i_trig is ignored in POST.
- DONE:
  - No further capture.
  - i_rd_en with o_count>0 reads rd_ptr, increments rd_ptr mod DEPTH and decrements o_count.
  - o_rd_data/o_rd_valid are registered and appear the cycle after i_rd_en (latency 1).
  - i_rd_en with o_count=0: o_rd_valid stays 0 and o_rd_data holds its previous value.
  - i_rd_en in any state other than DONE is ignored.
- i_arm in any state restarts from a cleared ARMED and takes priority over i_trig and i_rd_en in the same cycle. A pending o_rd_valid still completes for that cycle.
- Readout order is oldest first. The trigger entry sits at position o_count − i_post_count − 1 of the drained sequence.
- o_count width is DEPTH_LOG2+1 so that the full value DEPTH is representable.
- The RAM is a single write port plus a single registered read port, inferable as block RAM.

Test Plan:
- Reset mid-capture: assert i_rst asynchronously while in POST → o_state=0, o_count=0, o_rd_valid=0, o_wrapped=0 immediately, without waiting for a clock edge.
- No-wrap window (DEPTH_LOG2=4): arm; 5 fetches at addr 0x0000..0x0004, with i_trig on the 5th; i_post_count=3; 3 more fetches → DONE with o_count=8. Drain gives addr 0..7 in order, each one cycle after i_rd_en, and o_wrapped=0.
- Wrap (DEPTH=16): arm; 40 fetches addr 0..39, trigger on addr 35, post=4 → o_count=16, o_wrapped=1, drain yields addr 24..39.
- Edge cases:
  - post=0 with i_trig and i_valid in the same cycle at addr 0x0010 → DONE, and the last drained entry is 0x0010.
  - i_trig in IDLE → state stays 0.
- Clock-enable and re-arm:
  - Toggle i_clk_en low for 3 cycles during ARMED with i_valid high → no captures and o_count unchanged.
  - Over-read after drain → o_rd_valid stays 0.
  - i_arm during DONE with o_count=5 → state 1, o_count=0.
